pc_fetch_ctrl: RTL

- Owns the program counter and produces the fetch address each cycle; the PC it drives is the in_PC seen by the branch unit.
- Consumes resolved branch outcomes (taken flag plus target PC) from the execute-stage branch unit and redirects fetch.
- On a taken branch it issues a timed flush of the younger pipeline stages, then resumes fetch at the target.
- Sits between the local-store instruction fetch and the decode/issue stages. Also handles the stop/halt condition and counts taken branches.

---
 rtl/pc_fetch_ctrl_pkg.sv | 26 ++
 rtl/pc_fetch_ctrl_checker.sv | 19 +
 rtl/pc_fetch_ctrl_sat_counter.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the program-counter fetch controller: FSM state
// encoding and the default fetch step / flush length agreed with issue.
package pc_fetch_ctrl_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    PCF_RUN   = 2'd0,
    PCF_FLUSH = 2'd1,
    PCF_HALT  = 2'd2
  } pcf_state_e;

  // Default PC increment per fetch (dual-issue fetch pair)
  localparam int PCF_FETCH_STEP   = 2;
  // Default number of cycles flush_out stays high after a redirect
  localparam int PCF_FLUSH_CYCLES = 3;
  // Width of the flush down-counter; covers FLUSH_CYCLES up to 15
  localparam int PCF_FLUSH_CNT_W  = 4;

  // A resolved taken branch redirects fetch unless a stop arrives with it
  function automatic logic pcf_is_redirect(input logic valid,
                                           input logic taken,
                                           input logic stop);
    return valid & taken & ~stop;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_checker.sv
// Structural invariants of the fetch controller outputs: a flushing or
// halted front end never presents a valid fetch, and flush never overlaps halt.
module pc_fetch_ctrl_checker (
  input logic clk,
  input logic reset,
  input logic fetch_valid,
  input logic flush_out,
  input logic halted
);

  a_no_valid_during_flush: assert property (
    @(posedge clk) disable iff (reset) !(flush_out && fetch_valid)
  );

  a_halt_is_quiet: assert property (
    @(posedge clk) disable iff (reset) halted |-> (!fetch_valid && !flush_out)
  );

endmodule

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Parameterised saturating up-counter with increment enable and
// asynchronous active-high reset. Sticks at all-ones once reached.
module pcf_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count enabled increments, holding at the maximum value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc_en && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller. Owns the PC that feeds local-store
// instruction fetch, redirects on taken branches with a timed flush of the
// younger stages, halts on stop, and counts accepted taken branches.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter int FETCH_STEP   = PCF_FETCH_STEP,
  parameter int FLUSH_CYCLES = PCF_FLUSH_CYCLES,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_in,
  input  logic                 br_valid,
  input  logic                 br_taken,
  input  logic [PC_WIDTH-1:0]  br_target,
  input  logic                 stop_in,
  output logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 fetch_valid,
  output logic                 flush_out,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam logic [PC_WIDTH-1:0]        STEP_C      = PC_WIDTH'(FETCH_STEP);
  localparam logic [PCF_FLUSH_CNT_W-1:0] FLUSH_INIT_C = PCF_FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  pcf_state_e                 state_r,       state_s;
  logic [PCF_FLUSH_CNT_W-1:0] flush_cnt_r,   flush_cnt_s;
  logic [PC_WIDTH-1:0]        fetch_pc_r,    fetch_pc_s;
  logic                       fetch_valid_r, fetch_valid_s;
  logic                       flush_out_r,   flush_out_s;
  logic                       halted_r,      halted_s;
  logic                       taken_inc_s;
  logic                       redirect_s;

  assign redirect_s = pcf_is_redirect(br_valid, br_taken, stop_in);

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    state_s       = state_r;
    flush_cnt_s   = flush_cnt_r;
    fetch_pc_s    = fetch_pc_r;
    fetch_valid_s = fetch_valid_r;
    flush_out_s   = flush_out_r;
    halted_s      = halted_r;
    taken_inc_s   = 1'b0;

    case (state_r)
      PCF_RUN: begin
        if (redirect_s) begin
          // Taken branch wins over stall; start the flush window
          fetch_pc_s    = br_target;
          fetch_valid_s = 1'b0;
          flush_out_s   = 1'b1;
          flush_cnt_s   = FLUSH_INIT_C;
          taken_inc_s   = 1'b1;
          state_s       = PCF_FLUSH;
        end else if (stop_in) begin
          // Any concurrent taken branch is dropped and not counted
          fetch_valid_s = 1'b0;
          halted_s      = 1'b1;
          state_s       = PCF_HALT;
        end else if (stall_in) begin
          fetch_pc_s    = fetch_pc_r;
          fetch_valid_s = fetch_valid_r;
        end else if (!fetch_valid_r) begin
          // First fetch after reset presents the reset PC before advancing
          fetch_valid_s = 1'b1;
        end else begin
          fetch_pc_s    = fetch_pc_r + STEP_C;
          fetch_valid_s = 1'b1;
        end
      end

      PCF_FLUSH: begin
        // Wrong-path branches and stops are ignored; stall does not extend flush
        fetch_valid_s = 1'b0;
        flush_out_s   = 1'b1;
        if (flush_cnt_r == {PCF_FLUSH_CNT_W{1'b0}}) begin
          flush_out_s   = 1'b0;
          fetch_valid_s = 1'b1;
          state_s       = PCF_RUN;
        end else begin
          flush_cnt_s   = flush_cnt_r - {{(PCF_FLUSH_CNT_W-1){1'b0}}, 1'b1};
        end
      end

      PCF_HALT: begin
        // Only reset leaves HALT
        fetch_valid_s = 1'b0;
        flush_out_s   = 1'b0;
        halted_s      = 1'b1;
      end

      default: begin
        state_s       = PCF_RUN;
        flush_cnt_s   = {PCF_FLUSH_CNT_W{1'b0}};
        fetch_valid_s = 1'b0;
        flush_out_s   = 1'b0;
        halted_s      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= PCF_RUN;
      flush_cnt_r   <= {PCF_FLUSH_CNT_W{1'b0}};
      fetch_pc_r    <= {PC_WIDTH{1'b0}};
      fetch_valid_r <= 1'b0;
      flush_out_r   <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      flush_cnt_r   <= flush_cnt_s;
      fetch_pc_r    <= fetch_pc_s;
      fetch_valid_r <= fetch_valid_s;
      flush_out_r   <= flush_out_s;
      halted_r      <= halted_s;
    end
  end

  pcf_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_taken_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc_en (taken_inc_s),
    .count  (taken_count)
  );

  pc_fetch_ctrl_checker u_checker (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid_r),
    .flush_out   (flush_out_r),
    .halted      (halted_r)
  );

  assign fetch_pc    = fetch_pc_r;
  assign fetch_valid = fetch_valid_r;
  assign flush_out   = flush_out_r;
  assign halted      = halted_r;

endmodule
